// File: rtl/amm_burst_tx.sv
// Avalon-MM burst master: write bursts of generated data, read bursts with compare descriptors and read-credit tracking.
// Optional feature macro: TX_RND_DATA_EN enables the LFSR data pattern (RND_DATA mode); without it data is fixed.
package amm_burst_tx_pkg;
  localparam int CMP_ADDR_W  = 31;
  localparam int CMP_WORDS_W = 10;
  localparam int CMP_OFF_W   = 4;

  typedef struct packed {
    logic [CMP_ADDR_W-1:0]  start_addr;
    logic [CMP_WORDS_W-1:0] words_count;
    logic [7:0]             data_ptrn;
    logic                   data_mode;
    logic [CMP_OFF_W-1:0]   start_off;
    logic [CMP_OFF_W-1:0]   end_off;
  } cmp_struct_t;

  typedef enum logic [1:0] {IDLE_S = 2'd0, WRITE_S = 2'd1, READ_S = 2'd2} state_t;
endpackage

module amm_burst_tx
  import amm_burst_tx_pkg::*;
#(
  parameter int AMM_DATA_W    = 128,
  parameter int AMM_ADDR_W    = 31,
  parameter int AMM_BURST_W   = 11,
  parameter int MAX_RD_BURSTS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    test_start_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_op_i,
  input  logic [AMM_ADDR_W-1:0]   cmd_addr_i,
  input  logic [AMM_BURST_W-2:0]  cmd_words_i,
  input  logic [7:0]              cmd_data_ptrn_i,
  input  logic                    cmd_data_mode_i,
  output logic [AMM_ADDR_W-1:0]   address_o,
  output logic [AMM_BURST_W-1:0]  burstcount_o,
  output logic                    write_o,
  output logic [AMM_DATA_W-1:0]   writedata_o,
  output logic [AMM_DATA_W/8-1:0] byteenable_o,
  output logic                    read_o,
  input  logic                    waitrequest_i,
  input  logic                    readdatavalid_i,
  output logic                    cmp_en_o,
  output cmp_struct_t             cmp_struct_o,
  output logic                    busy_o,
  output state_t                  state_o
);
  localparam int DATA_B_W = AMM_DATA_W / 8;
  localparam int WORDS_W  = AMM_BURST_W - 1;
  localparam int PTR_W    = (MAX_RD_BURSTS > 1) ? $clog2(MAX_RD_BURSTS) : 1;
  localparam int CNT_W    = $clog2(MAX_RD_BURSTS + 1);

  // Handshakes: a command transfers on a cycle with cmd_valid_i & cmd_ready_o; an Avalon
  // beat or read burst transfers on a cycle with write_o/read_o high and waitrequest_i low.

  state_t                  state_q, state_d;
  logic [AMM_ADDR_W-1:0]   addr_q, addr_d;
  logic [AMM_BURST_W-1:0]  burst_q, burst_d;
  logic [WORDS_W-1:0]      words_q, words_d;
  logic [7:0]              ptrn_q, ptrn_d;
  logic                    mode_q, mode_d;
  logic                    write_q, write_d;
  logic                    read_q, read_d;
  logic [AMM_DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_B_W-1:0]     be_q, be_d;
  logic                    cmp_en_q, cmp_en_d;
  cmp_struct_t             cmp_q, cmp_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        inflight_q, inflight_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WORDS_W-1:0]      bcnt_q, bcnt_d;
  logic [WORDS_W-1:0]      len_q [MAX_RD_BURSTS];
  logic [WORDS_W-1:0]      len_d [MAX_RD_BURSTS];
  logic                    push, pop;

`ifndef TX_RND_DATA_EN
  logic unused_mode;
  assign unused_mode = cmd_data_mode_i;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_RD_BURSTS - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    burst_d    = burst_q;
    words_d    = words_q;
    ptrn_d     = ptrn_q;
    mode_d     = mode_q;
    cmp_en_d   = 1'b0;
    cmp_d      = cmp_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    bcnt_d     = bcnt_q;
    len_d      = len_q;
    push       = 1'b0;
    pop        = 1'b0;

    case (state_q)
      IDLE_S: begin
        if (cmd_valid_i) begin
          addr_d  = cmd_addr_i;
          words_d = cmd_words_i;
          ptrn_d  = cmd_data_ptrn_i;
          burst_d = AMM_BURST_W'(cmd_words_i) + AMM_BURST_W'(1);
`ifdef TX_RND_DATA_EN
          mode_d  = cmd_data_mode_i;
`else
          mode_d  = 1'b0;
`endif
          state_d = cmd_op_i ? READ_S : WRITE_S;
        end
      end
      WRITE_S: begin
        if (write_q && !waitrequest_i) begin
          if (words_q == '0) begin
            state_d = IDLE_S;
          end else begin
            words_d = words_q - WORDS_W'(1);
`ifdef TX_RND_DATA_EN
            if (mode_q) ptrn_d = {ptrn_q[6:0], ptrn_q[7] ^ ptrn_q[5] ^ ptrn_q[4] ^ ptrn_q[3]};
`endif
          end
        end
      end
      READ_S: begin
        if (read_q && !waitrequest_i) begin
          state_d               = IDLE_S;
          push                  = 1'b1;
          cmp_en_d              = 1'b1;
          cmp_d                 = '0;
          cmp_d.start_addr      = CMP_ADDR_W'(addr_q);
          cmp_d.words_count     = CMP_WORDS_W'(words_q);
          cmp_d.data_ptrn       = ptrn_q;
          cmp_d.data_mode       = mode_q;
        end
      end
      default: state_d = IDLE_S;
    endcase

    // Beats with nothing outstanding are stray and must not disturb the head counter.
    if (readdatavalid_i && inflight_q != '0) begin
      if (bcnt_q == len_q[rd_ptr_q]) begin
        pop      = 1'b1;
        bcnt_d   = '0;
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        bcnt_d = bcnt_q + WORDS_W'(1);
      end
    end
    if (push) begin
      len_d[wr_ptr_q] = words_q;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (push && !pop)      inflight_d = inflight_q + CNT_W'(1);
    else if (!push && pop) inflight_d = inflight_q - CNT_W'(1);

    if (test_start_i) begin
      state_d    = IDLE_S;
      inflight_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      bcnt_d     = '0;
      cmp_en_d   = 1'b0;
    end

    write_d = (state_d == WRITE_S);
    read_d  = (state_d == READ_S) && (inflight_d < CNT_W'(MAX_RD_BURSTS));
    be_d    = write_d ? '1 : '0;
    wdata_d = {DATA_B_W{ptrn_d}};
    busy_d  = (state_q != IDLE_S) || (inflight_q != '0);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE_S;
      addr_q     <= '0;
      burst_q    <= '0;
      words_q    <= '0;
      ptrn_q     <= '0;
      mode_q     <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      cmp_en_q   <= 1'b0;
      cmp_q      <= '0;
      busy_q     <= 1'b0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      bcnt_q     <= '0;
      len_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      burst_q    <= burst_d;
      words_q    <= words_d;
      ptrn_q     <= ptrn_d;
      mode_q     <= mode_d;
      write_q    <= write_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      cmp_en_q   <= cmp_en_d;
      cmp_q      <= cmp_d;
      busy_q     <= busy_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      bcnt_q     <= bcnt_d;
      len_q      <= len_d;
    end
  end

  assign cmd_ready_o  = (state_q == IDLE_S);
  assign address_o    = addr_q;
  assign burstcount_o = burst_q;
  assign write_o      = write_q;
  assign writedata_o  = wdata_q;
  assign byteenable_o = be_q;
  assign read_o       = read_q;
  assign cmp_en_o     = cmp_en_q;
  assign cmp_struct_o = cmp_q;
  assign busy_o       = busy_q;
  assign state_o      = state_q;
endmodule

// File: tb/tb_amm_burst_tx.sv
// Directed bench for amm_burst_tx: write data patterns, stalls, read descriptors, read credits, test_start abort.
module tb_amm_burst_tx;
  import amm_burst_tx_pkg::*;

  localparam int AW = 31;
  localparam int BW = 11;
  localparam int NB = 16;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            test_start_i = 1'b0;
  logic            cmd_valid_i = 1'b0;
  logic            cmd_ready_o;
  logic            cmd_op_i = 1'b0;
  logic [AW-1:0]   cmd_addr_i = '0;
  logic [BW-2:0]   cmd_words_i = '0;
  logic [7:0]      cmd_data_ptrn_i = '0;
  logic            cmd_data_mode_i = 1'b0;
  logic [AW-1:0]   address_o;
  logic [BW-1:0]   burstcount_o;
  logic            write_o;
  logic [8*NB-1:0] writedata_o;
  logic [NB-1:0]   byteenable_o;
  logic            read_o;
  logic            waitrequest_i = 1'b0;
  logic            readdatavalid_i = 1'b0;
  logic            cmp_en_o;
  cmp_struct_t     cmp_struct_o;
  logic            busy_o;
  state_t          state_o;

  int tests_run = 0;
  int failed    = 0;

  amm_burst_tx dut (
    .clk_i(clk_i), .rst_i(rst_i), .test_start_i(test_start_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_addr_i(cmd_addr_i), .cmd_words_i(cmd_words_i), .cmd_data_ptrn_i(cmd_data_ptrn_i),
    .cmd_data_mode_i(cmd_data_mode_i), .address_o(address_o), .burstcount_o(burstcount_o),
    .write_o(write_o), .writedata_o(writedata_o), .byteenable_o(byteenable_o),
    .read_o(read_o), .waitrequest_i(waitrequest_i), .readdatavalid_i(readdatavalid_i),
    .cmp_en_o(cmp_en_o), .cmp_struct_o(cmp_struct_o), .busy_o(busy_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failed++;
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input logic op, input logic [AW-1:0] addr, input logic [BW-2:0] words,
                          input logic [7:0] ptrn, input logic mode);
    cmd_valid_i     = 1'b1;
    cmd_op_i        = op;
    cmd_addr_i      = addr;
    cmd_words_i     = words;
    cmd_data_ptrn_i = ptrn;
    cmd_data_mode_i = mode;
    tick();
    cmd_valid_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    tests_run++;
    if ({write_o, read_o, cmp_en_o, busy_o} !== 4'b0000) begin
      failed++;
      $display("FAIL reset_ctrl: got w/r/cmp/busy=%b required 0000", {write_o, read_o, cmp_en_o, busy_o});
    end
    tests_run++;
    if (address_o !== '0 || burstcount_o !== '0 || writedata_o !== '0 || byteenable_o !== '0 || cmp_struct_o !== '0) begin
      failed++;
      $display("FAIL reset_data: got addr=%h bc=%h wd=%h be=%h cmp=%h required all zero",
               address_o, burstcount_o, writedata_o, byteenable_o, cmp_struct_o);
    end
    tests_run++;
    if (cmd_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_ready: got %b required 1", cmd_ready_o);
    end
  endtask

  task automatic test_fix_write();
    logic [8*NB-1:0] exp_wd;
    exp_wd = {NB{8'hA5}};
    send_cmd(1'b0, AW'(32'h100), 10'd3, 8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (write_o !== 1'b1 || writedata_o !== exp_wd || address_o !== AW'(32'h100) ||
          burstcount_o !== 11'd4 || byteenable_o !== {NB{1'b1}}) begin
        failed++;
        $display("FAIL fix_write beat %0d: got w=%b wd=%h addr=%h bc=%0d be=%h required 1 %h 100 4 ffff",
                 i, write_o, writedata_o, address_o, burstcount_o, byteenable_o, exp_wd);
      end
      tick();
    end
    tests_run++;
    if (write_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      failed++;
      $display("FAIL fix_write_end: got w=%b ready=%b required 0 1", write_o, cmd_ready_o);
    end
  endtask

  task automatic test_rnd_write();
    logic [7:0] exp_b [3];
`ifdef TX_RND_DATA_EN
    exp_b = '{8'h08, 8'h11, 8'h23};
`else
    exp_b = '{8'h08, 8'h08, 8'h08};
`endif
    send_cmd(1'b0, AW'(32'h200), 10'd2, 8'h08, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (write_o !== 1'b1 || writedata_o !== {NB{exp_b[i]}}) begin
        failed++;
        $display("FAIL rnd_write beat %0d: got w=%b wd=%h required 1 byte %h", i, write_o, writedata_o, exp_b[i]);
      end
      tick();
    end
    tests_run++;
    if (write_o !== 1'b0) begin
      failed++;
      $display("FAIL rnd_write_end: got w=%b required 0", write_o);
    end
  endtask

  task automatic test_write_stall();
    logic [7:0] exp_b [3];
    int acc;
`ifdef TX_RND_DATA_EN
    exp_b = '{8'h08, 8'h11, 8'h23};
`else
    exp_b = '{8'h08, 8'h08, 8'h08};
`endif
    acc = 0;
    send_cmd(1'b0, AW'(32'h300), 10'd2, 8'h08, 1'b1);
    for (int c = 0; c < 10; c++) begin
      waitrequest_i = (c >= 1 && c <= 3);
      if (write_o) begin
        tests_run++;
        if (acc >= 3) begin
          failed++;
          $display("FAIL stall_extra_beat cycle %0d: got write_o=1 after 3 beats required 0", c);
        end else if (writedata_o !== {NB{exp_b[acc]}} || address_o !== AW'(32'h300) || burstcount_o !== 11'd3) begin
          failed++;
          $display("FAIL stall_beat cycle %0d: got wd=%h addr=%h bc=%0d required byte %h addr 300 bc 3",
                   c, writedata_o, address_o, burstcount_o, exp_b[acc]);
        end
        if (!waitrequest_i) acc++;
      end
      tick();
    end
    waitrequest_i = 1'b0;
    tests_run++;
    if (acc != 3) begin
      failed++;
      $display("FAIL stall_beat_count: got %0d required 3", acc);
    end
  endtask

  task automatic test_read_stall();
    cmp_struct_t exp_c;
    int rd_cycles;
    int cmp_cnt;
    exp_c             = '0;
    exp_c.start_addr  = 31'h40;
    exp_c.words_count = 10'd7;
    exp_c.data_ptrn   = 8'h5A;
    exp_c.data_mode   = 1'b0;
    rd_cycles = 0;
    cmp_cnt   = 0;
    waitrequest_i = 1'b1;
    send_cmd(1'b1, AW'(32'h40), 10'd7, 8'h5A, 1'b0);
    for (int c = 0; c < 6; c++) begin
      waitrequest_i = (c < 2);
      if (read_o) rd_cycles++;
      if (cmp_en_o) begin
        cmp_cnt++;
        tests_run++;
        if (cmp_struct_o !== exp_c || c != 3) begin
          failed++;
          $display("FAIL read_cmp: got struct=%h at cycle %0d required %h at cycle 3", cmp_struct_o, c, exp_c);
        end
      end
      tick();
    end
    tests_run++;
    if (rd_cycles != 3 || cmp_cnt != 1) begin
      failed++;
      $display("FAIL read_stall_counts: got read cycles %0d cmp pulses %0d required 3 1", rd_cycles, cmp_cnt);
    end
    readdatavalid_i = 1'b1;
    repeat (7) tick();
    readdatavalid_i = 1'b0;
    tick();
    tick();
    tests_run++;
    if (busy_o !== 1'b1) begin
      failed++;
      $display("FAIL read_busy_7beats: got %b required 1", busy_o);
    end
    readdatavalid_i = 1'b1;
    tick();
    readdatavalid_i = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 1'b0) begin
      failed++;
      $display("FAIL read_busy_8beats: got %b required 0", busy_o);
    end
  endtask

  task automatic test_credit();
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b1, AW'(32'h10 + i), 10'd0, 8'h00, 1'b0);
      tests_run++;
      if (read_o !== 1'b1) begin
        failed++;
        $display("FAIL credit_issue %0d: got read_o=%b required 1", i, read_o);
      end
      tick();
    end
    send_cmd(1'b1, AW'(32'h14), 10'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (read_o !== 1'b0 || state_o !== READ_S) begin
        failed++;
        $display("FAIL credit_block %0d: got read_o=%b state=%0d required 0 2", i, read_o, state_o);
      end
      tick();
    end
    readdatavalid_i = 1'b1;
    tick();
    readdatavalid_i = 1'b0;
    tests_run++;
    if (read_o !== 1'b1) begin
      failed++;
      $display("FAIL credit_release: got read_o=%b required 1", read_o);
    end
    tick();
    tests_run++;
    if (read_o !== 1'b0 || cmp_en_o !== 1'b1 || cmp_struct_o.start_addr !== 31'h14) begin
      failed++;
      $display("FAIL credit_fifth: got read_o=%b cmp_en=%b addr=%h required 0 1 14",
               read_o, cmp_en_o, cmp_struct_o.start_addr);
    end
    readdatavalid_i = 1'b1;
    repeat (4) tick();
    readdatavalid_i = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 1'b0) begin
      failed++;
      $display("FAIL credit_drain: got busy=%b required 0", busy_o);
    end
    // stray beats with nothing outstanding, then a 2-beat read
    readdatavalid_i = 1'b1;
    repeat (2) tick();
    readdatavalid_i = 1'b0;
    send_cmd(1'b1, AW'(32'h20), 10'd1, 8'h00, 1'b0);
    tick();
    readdatavalid_i = 1'b1;
    tick();
    readdatavalid_i = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 1'b1) begin
      failed++;
      $display("FAIL stray_first_beat: got busy=%b required 1", busy_o);
    end
    readdatavalid_i = 1'b1;
    tick();
    readdatavalid_i = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 1'b0) begin
      failed++;
      $display("FAIL stray_second_beat: got busy=%b required 0", busy_o);
    end
  endtask

  task automatic test_abort();
    send_cmd(1'b1, AW'(32'h50), 10'd0, 8'h00, 1'b0);
    tick();
    send_cmd(1'b1, AW'(32'h51), 10'd0, 8'h00, 1'b0);
    tick();
    send_cmd(1'b0, AW'(32'h400), 10'd7, 8'h3C, 1'b0);
    tests_run++;
    if (write_o !== 1'b1) begin
      failed++;
      $display("FAIL abort_beat1: got write_o=%b required 1", write_o);
    end
    tick();
    tests_run++;
    if (write_o !== 1'b1 || busy_o !== 1'b1) begin
      failed++;
      $display("FAIL abort_beat2: got write_o=%b busy=%b required 1 1", write_o, busy_o);
    end
    test_start_i = 1'b1;
    tick();
    test_start_i = 1'b0;
    tests_run++;
    if (write_o !== 1'b0 || read_o !== 1'b0 || cmp_en_o !== 1'b0 || cmd_ready_o !== 1'b1 || state_o !== IDLE_S) begin
      failed++;
      $display("FAIL abort_next: got w=%b r=%b cmp=%b ready=%b state=%0d required 0 0 0 1 0",
               write_o, read_o, cmp_en_o, cmd_ready_o, state_o);
    end
    tick();
    tests_run++;
    if (busy_o !== 1'b0) begin
      failed++;
      $display("FAIL abort_busy: got %b required 0", busy_o);
    end
    send_cmd(1'b1, AW'(32'h60), 10'd0, 8'h00, 1'b0);
    tick();
    readdatavalid_i = 1'b1;
    tick();
    readdatavalid_i = 1'b0;
    tick();
    tests_run++;
    if (busy_o !== 1'b0) begin
      failed++;
      $display("FAIL abort_queue_empty: got busy=%b required 0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_fix_write();
    test_rnd_write();
    test_write_stall();
    test_read_stall();
    test_credit();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
